// File: rtl/jtag_host_pkg.sv
// Shared types and constants for the host-side JTAG driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: command opcodes, FSM states, TMS preamble patterns (LSB sent first).
package jtag_host_pkg;

  typedef enum logic [1:0] {
    OP_TLR = 2'b00,
    OP_IR  = 2'b01,
    OP_DR  = 2'b10,
    OP_RUN = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_PRE,
    ST_SHIFT,
    ST_POST,
    ST_DONE
  } state_e;

  localparam int         TLR_TMS_CNT = 5;
  localparam logic [2:0] PRE_DR      = 3'b001;   // SelDR, CapDR, ShDR
  localparam logic [3:0] PRE_IR      = 4'b0011;  // SelDR, SelIR, CapIR, ShIR

  // TMS value for preamble period idx of a shift command.
  function automatic logic pre_tms(op_e op, logic [1:0] idx);
    logic [3:0] pat;
    pat = (op == OP_IR) ? PRE_IR : {1'b0, PRE_DR};
    return pat[idx];
  endfunction

  // Index of the final preamble period (the one that lands in Shift-xR).
  function automatic logic [1:0] pre_last(op_e op);
    return (op == OP_IR) ? 2'd3 : 2'd2;
  endfunction

endpackage

// File: rtl/jtag_host_driver_if.sv
// Command/response port of the JTAG host driver.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready on commands; responses are a 1-clk pulse, no backpressure.
// Ports: cmd_valid, cmd_ready, cmd_op, cmd_len, cmd_data, rsp_valid, rsp_data.
interface jtag_host_driver_if #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_tck_gen.sv
// TCK generator: low CLK_DIV clk, high CLK_DIV clk, held low while disabled.
// Latency: first rising edge CLK_DIV clk after enable; tck_o is registered.
// Backpressure: none; en gates the clock, ticks flag the clk edge where tck_o will rise/fall.
// Ports: clk, reset, en in; tck_o, rise_tick, fall_tick out.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck_o,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             wrap;

  assign wrap      = (cnt_q == CNT_W'(CLK_DIV - 1));
  // Ticks are combinational look-aheads: tck_o toggles on the same edge.
  assign rise_tick = en & ~tck_o & wrap;
  assign fall_tick = en &  tck_o & wrap;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt_q <= '0;
      tck_o <= 1'b0;
    end else if (wrap) begin
      cnt_q <= '0;
      tck_o <= ~tck_o;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/jtag_host_driver.sv
// Host JTAG master: runs TLR/IR/DR/RUN commands from RTI back to RTI, returns captured TDO.
// Latency: N TCK periods per command (DR N+5, IR N+6, RUN N, TLR 6); rsp_valid 1 clk after the last falling TCK.
// Backpressure: cmd_ready low from accept until the rsp_valid clk; responses cannot be stalled.
// Ports: clk, reset (sync, active-high), bus (command/response), tck_o/tms_o/tdi_o/trst_n_o out, tdo_i in.
module jtag_host_driver
  import jtag_host_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                reset,
  jtag_host_driver_if.slave   bus,
  output logic                tck_o,
  output logic                tms_o,
  output logic                tdi_o,
  output logic                trst_n_o,
  input  logic                tdo_i
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e             state_q, state_n;
  op_e                op_q, op_n, op_c;
  logic [2:0]         pidx_q, pidx_n;
  logic [IDX_W-1:0]   sidx_q, sidx_n, nxt_idx;
  logic [LEN_W-1:0]   len_q, len_n, len_c;
  logic [MAX_LEN-1:0] data_q, data_n;
  logic [MAX_LEN-1:0] cap_q, cap_n;
  logic [MAX_LEN-1:0] rspd_q, rspd_n;
  logic               run_q, run_n;
  logic               tms_q, tms_n;
  logic               tdi_q, tdi_n;
  logic               trst_q, trst_n;
  logic               rdy_q, rdy_n;
  logic               rspv_q, rspv_n;
  logic               act_q, act_n;     // a host command (not the power-on INIT) is in flight
  logic               rise_tick, fall_tick;
  logic               last_shift;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
    .clk       (clk),
    .reset     (reset),
    .en        (run_q),
    .tck_o     (tck_o),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign op_c       = op_e'(bus.cmd_op);
  assign len_c      = (bus.cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cmd_len;
  assign nxt_idx    = sidx_q + IDX_W'(1);
  assign last_shift = (LEN_W'(sidx_q) == len_q - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      op_q    <= OP_TLR;
      pidx_q  <= '0;
      sidx_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      rspd_q  <= '0;
      run_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      trst_q  <= 1'b0;
      rdy_q   <= 1'b0;
      rspv_q  <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      op_q    <= op_n;
      pidx_q  <= pidx_n;
      sidx_q  <= sidx_n;
      len_q   <= len_n;
      data_q  <= data_n;
      cap_q   <= cap_n;
      rspd_q  <= rspd_n;
      run_q   <= run_n;
      tms_q   <= tms_n;
      tdi_q   <= tdi_n;
      trst_q  <= trst_n;
      rdy_q   <= rdy_n;
      rspv_q  <= rspv_n;
      act_q   <= act_n;
    end
  end

  // Each period's TMS/TDI is loaded on the edge where TCK falls (fall_tick),
  // or on the accept edge for the first period of a command.
  always_comb begin
    state_n = state_q;
    op_n    = op_q;
    pidx_n  = pidx_q;
    sidx_n  = sidx_q;
    len_n   = len_q;
    data_n  = data_q;
    cap_n   = cap_q;
    rspd_n  = rspd_q;
    run_n   = run_q;
    tms_n   = tms_q;
    tdi_n   = tdi_q;
    trst_n  = trst_q;
    rdy_n   = rdy_q;
    rspv_n  = 1'b0;
    act_n   = act_q;

    case (state_q)
      ST_INIT: begin
        if (!run_q) begin
          // Out of reset: release TRST first, start the TLR walk on the next clk.
          if (!trst_q) begin
            trst_n = 1'b1;
          end else begin
            run_n  = 1'b1;
            pidx_n = '0;
            tms_n  = 1'b1;
          end
        end else if (fall_tick) begin
          if (pidx_q == 3'(TLR_TMS_CNT)) begin
            run_n   = 1'b0;
            state_n = ST_DONE;
          end else begin
            pidx_n = pidx_q + 3'd1;
            tms_n  = (pidx_q + 3'd1) < 3'(TLR_TMS_CNT);
          end
        end
      end

      ST_IDLE: begin
        if (bus.cmd_valid && rdy_q) begin
          rdy_n  = 1'b0;
          act_n  = 1'b1;
          cap_n  = '0;
          op_n   = op_c;
          len_n  = len_c;
          data_n = bus.cmd_data;
          pidx_n = '0;
          sidx_n = '0;
          tdi_n  = 1'b0;
          case (op_c)
            OP_TLR: begin
              state_n = ST_INIT;
              run_n   = 1'b1;
              tms_n   = 1'b1;
            end
            OP_RUN: begin
              if (len_c == '0) begin
                state_n = ST_DONE;
              end else begin
                state_n = ST_SHIFT;
                run_n   = 1'b1;
                tms_n   = 1'b0;
              end
            end
            default: begin
              if (len_c == '0) begin
                state_n = ST_DONE;
              end else begin
                state_n = ST_PRE;
                run_n   = 1'b1;
                tms_n   = pre_tms(op_c, 2'd0);
              end
            end
          endcase
        end
      end

      ST_PRE: begin
        if (fall_tick) begin
          if (pidx_q[1:0] == pre_last(op_q)) begin
            state_n = ST_SHIFT;
            sidx_n  = '0;
            tms_n   = (len_q == LEN_W'(1));
            tdi_n   = data_q[0];
          end else begin
            pidx_n = pidx_q + 3'd1;
            tms_n  = pre_tms(op_q, pidx_q[1:0] + 2'd1);
          end
        end
      end

      ST_SHIFT: begin
        if (rise_tick && op_q != OP_RUN) begin
          cap_n[sidx_q] = tdo_i;
        end
        if (fall_tick) begin
          if (last_shift) begin
            tdi_n = 1'b0;
            if (op_q == OP_RUN) begin
              run_n   = 1'b0;
              state_n = ST_DONE;
            end else begin
              state_n = ST_POST;
              pidx_n  = '0;
              tms_n   = 1'b1;           // Update-xR
            end
          end else begin
            sidx_n = nxt_idx;
            // Exit1 is entered by raising TMS on the final shift period.
            tms_n  = (op_q != OP_RUN) && (LEN_W'(nxt_idx) == len_q - LEN_W'(1));
            tdi_n  = (op_q != OP_RUN) && data_q[nxt_idx];
          end
        end
      end

      ST_POST: begin
        if (fall_tick) begin
          if (pidx_q[0]) begin
            run_n   = 1'b0;
            state_n = ST_DONE;
          end else begin
            pidx_n = 3'd1;
            tms_n  = 1'b0;              // back to RTI
          end
        end
      end

      ST_DONE: begin
        rspv_n  = act_q;
        if (act_q) begin
          rspd_n = cap_q;
        end
        rdy_n   = 1'b1;
        act_n   = 1'b0;
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_INIT;
      end
    endcase
  end

  assign bus.cmd_ready = rdy_q;
  assign bus.rsp_valid = rspv_q;
  assign bus.rsp_data  = rspd_q;
  assign tms_o         = tms_q;
  assign tdi_o         = tdi_q;
  assign trst_n_o      = trst_q;

endmodule

// File: tb/tb_jtag_host_driver.sv
// Bench for jtag_host_driver with a bypass-register TAP (TDO = TDI one period later).
module tb_jtag_host_driver;
  import jtag_host_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  typedef struct {
    logic [1:0]  op;
    int          len;
    logic [31:0] data;
    int          periods;
    logic [63:0] tms;
    logic [63:0] tdi;
    logic [31:0] rsp;
    bit          b2b;     // next command is issued on this command's rsp_valid clk
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tck_o, tms_o, tdi_o, trst_n_o;
  logic tdo_i = 1'b0;

  jtag_host_driver_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  jtag_host_driver #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .tck_o    (tck_o),
    .tms_o    (tms_o),
    .tdi_o    (tdi_o),
    .trst_n_o (trst_n_o),
    .tdo_i    (tdo_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: per-period TMS/TDI captured on TCK rise, response pulse count.
  int          pcnt = 0;
  int          rsp_cnt = 0;
  logic [63:0] tms_log = '0;
  logic [63:0] tdi_log = '0;
  logic        bp_sreg = 1'b0;

  always @(posedge tck_o) begin
    if (pcnt < 64) begin
      tms_log[pcnt] = tms_o;
      tdi_log[pcnt] = tdi_o;
    end
    pcnt = pcnt + 1;
    bp_sreg <= tdi_o;
  end

  always @(negedge tck_o) tdo_i <= bp_sreg;

  always @(negedge clk) if (bus.rsp_valid === 1'b1) rsp_cnt = rsp_cnt + 1;

  task automatic clear_mon();
    pcnt    = 0;
    rsp_cnt = 0;
    tms_log = '0;
    tdi_log = '0;
  endtask

  // Reference: period sequence and bypass-captured data straight from the protocol rules.
  function automatic vec_t model(input logic [1:0] op, input int len, input logic [31:0] data);
    vec_t v;
    int n, pre;
    logic [63:0] m;
    v.op = op; v.len = len; v.data = data; v.b2b = 1'b0;
    v.periods = 0; v.tms = '0; v.tdi = '0; v.rsp = '0;
    n = (len > MAX_LEN) ? MAX_LEN : len;
    m = (64'd1 << n) - 64'd1;
    if (op == OP_TLR) begin
      v.periods = 6;
      v.tms     = 64'h1F;
    end else if (op == OP_RUN) begin
      v.periods = n;
    end else if (n > 0) begin
      pre       = (op == OP_IR) ? 4 : 3;
      v.periods = n + pre + 2;
      v.tms     = ((op == OP_IR) ? 64'h3 : 64'h1) | (64'h3 << (pre + n - 1));
      v.tdi     = ({32'h0, data} & m) << pre;
      v.rsp     = 32'(({32'h0, data} << 1) & m);
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input bit prev_b2b, input string tag);
    int w, lat;
    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check({tag, " ready_before_issue"}, bus.cmd_ready, 1);
    if (prev_b2b) check({tag, " b2b_no_wait"}, w, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_len   = LEN_W'(v.len);
    bus.cmd_data  = v.data;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    clear_mon();
    @(negedge clk);
    lat = 1;
    check({tag, " ready_dropped"}, bus.cmd_ready, 0);
    while (bus.rsp_valid !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " rsp_latency"}, lat, 2 * CLK_DIV * v.periods + 2);
    check({tag, " ready_on_rsp"}, bus.cmd_ready, 1);
    check({tag, " periods"}, pcnt, v.periods);
    check({tag, " tms_seq"}, tms_log, v.tms);
    check({tag, " tdi_seq"}, tdi_log, v.tdi);
    check({tag, " rsp_data"}, bus.rsp_data, v.rsp);
    if (!v.b2b) begin
      repeat (3) @(negedge clk);
      #2;
      check({tag, " rsp_pulses"}, rsp_cnt, 1);
    end
  endtask

  // Assert reset 3 clk, check reset values, release and check the INIT walk.
  task automatic reset_and_init(input string tag);
    int c;
    reset = 1'b1;
    @(negedge clk);
    check({tag, " reset_outs"},
          {bus.cmd_ready, bus.rsp_valid, tck_o, tms_o, tdi_o, trst_n_o}, 6'b000100);
    check({tag, " reset_rsp_data"}, bus.rsp_data, 0);
    check({tag, " no_rsp_on_abort"}, rsp_cnt, 0);
    repeat (2) @(negedge clk);
    clear_mon();
    reset = 1'b0;
    @(negedge clk);
    c = 1;
    check({tag, " trst_released"}, trst_n_o, 1);
    while (bus.cmd_ready !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check({tag, " init_ready_24_28clk"}, (c >= 24 && c <= 28), 1);
    check({tag, " init_periods"}, pcnt, 6);
    check({tag, " init_tms"}, tms_log, 64'h1F);
    check({tag, " init_tdi"}, tdi_log, 0);
    check({tag, " init_no_rsp"}, rsp_cnt, 0);
    check({tag, " init_rsp_data"}, bus.rsp_data, 0);
  endtask

  vec_t tbl[9];
  vec_t rv;
  bit   prev;

  initial begin
    tbl[0] = '{op:2'b01, len:4,  data:32'h5,        periods:10, tms:64'h183,
               tdi:64'h50,           rsp:32'hA,        b2b:1'b0};
    tbl[1] = '{op:2'b10, len:8,  data:32'hA5,       periods:13, tms:64'hC01,
               tdi:64'h528,          rsp:32'h4A,       b2b:1'b0};
    tbl[2] = '{op:2'b10, len:0,  data:32'hFFFF,     periods:0,  tms:64'h0,
               tdi:64'h0,            rsp:32'h0,        b2b:1'b0};
    tbl[3] = '{op:2'b10, len:40, data:32'hFFFFFFFF, periods:37, tms:64'hC_0000_0001,
               tdi:64'h7_FFFF_FFF8,  rsp:32'hFFFFFFFE, b2b:1'b0};
    tbl[4] = '{op:2'b11, len:3,  data:32'hFFFF,     periods:3,  tms:64'h0,
               tdi:64'h0,            rsp:32'h0,        b2b:1'b1};
    tbl[5] = '{op:2'b10, len:2,  data:32'h3,        periods:7,  tms:64'h31,
               tdi:64'h18,           rsp:32'h2,        b2b:1'b0};
    tbl[6] = '{op:2'b01, len:1,  data:32'h1,        periods:7,  tms:64'h33,
               tdi:64'h10,           rsp:32'h0,        b2b:1'b0};
    tbl[7] = '{op:2'b00, len:9,  data:32'h1234,     periods:6,  tms:64'h1F,
               tdi:64'h0,            rsp:32'h0,        b2b:1'b0};
    tbl[8] = '{op:2'b11, len:0,  data:32'h0,        periods:0,  tms:64'h0,
               tdi:64'h0,            rsp:32'h0,        b2b:1'b0};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;

    @(negedge clk);
    reset_and_init("por");

    prev = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run_vec(tbl[i], prev, $sformatf("vec%0d", i));
      prev = tbl[i].b2b;
    end

    prev = 1'b0;
    for (int r = 0; r < 14; r++) begin
      rv = model(2'($urandom_range(0, 3)), int'($urandom_range(0, 40)), $urandom);
      rv.b2b = ($urandom_range(0, 3) == 0);
      run_vec(rv, prev, $sformatf("rnd%0d", r));
      prev = rv.b2b;
    end
    repeat (4) @(negedge clk);

    // Abort a long DR shift mid-stream.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    bus.cmd_len   = LEN_W'(32);
    bus.cmd_data  = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    clear_mon();
    repeat (30) @(negedge clk);
    check("abort in_shift", (pcnt >= 4), 1);
    reset_and_init("abort");
    run_vec(tbl[1], 1'b0, "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
